// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache widths and types used by the read-port arbiter.
package wt_cache_pkg;
  localparam int unsigned DCACHE_TAG_WIDTH       = 44;
  localparam int unsigned DCACHE_CL_IDX_WIDTH    = 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH    = 4;
  localparam int unsigned DCACHE_RD_STARVE_LIMIT = 15;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]    tag;
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] off;
    logic                           tag_only;
  } dcache_rd_req_t;
endpackage

// File: rtl/wt_rr_arb_class.sv
// Round-robin pick within one priority class: first requester at or above ptr, wrapping.
module wt_rr_arb_class #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [PtrW-1:0]     ptr,
  input  logic [NumPorts-1:0] req,
  output logic [NumPorts-1:0] gnt,
  output logic [PtrW-1:0]     idx,
  output logic                any
);
  logic [PtrW:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      pos = {1'b0, ptr} + (PtrW+1)'(i);
      if (pos >= (PtrW+1)'(NumPorts)) pos = pos - (PtrW+1)'(NumPorts);
      if (!any && req[pos[PtrW-1:0]]) begin
        any                  = 1'b1;
        gnt[pos[PtrW-1:0]]   = 1'b1;
        idx                  = pos[PtrW-1:0];
      end
    end
  end
endmodule

// File: rtl/wt_dcache_rd_arb.sv
// N-port dcache read arbiter: two priority classes with round-robin inside each,
// a starvation override for the low class, and one registered stage to the SRAMs.
module wt_dcache_rd_arb
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned TagWidth    = DCACHE_TAG_WIDTH,
  parameter int unsigned IdxWidth    = DCACHE_CL_IDX_WIDTH,
  parameter int unsigned OffWidth    = DCACHE_OFFSET_WIDTH,
  parameter int unsigned StarveLimit = DCACHE_RD_STARVE_LIMIT,
  localparam int unsigned PortW      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumPorts-1:0]          rd_req_i,
  input  logic [NumPorts-1:0]          rd_prio_i,
  input  logic [NumPorts-1:0]          rd_tag_only_i,
  input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
  input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
  input  logic [NumPorts*OffWidth-1:0] rd_off_i,
  output logic [NumPorts-1:0]          rd_ack_o,
  input  logic                         wr_cl_vld_i,
  output logic                         mem_vld_o,
  output logic [PortW-1:0]             mem_port_o,
  output logic [TagWidth-1:0]          mem_tag_o,
  output logic [IdxWidth-1:0]          mem_idx_o,
  output logic [OffWidth-1:0]          mem_off_o,
  output logic                         mem_tag_only_o,
  output logic                         starved_o
);
  typedef struct packed {
    logic [TagWidth-1:0] tag;
    logic [IdxWidth-1:0] idx;
    logic [OffWidth-1:0] off;
    logic                tag_only;
  } rd_req_t;

  localparam logic [7:0] Limit = 8'(StarveLimit);

  logic [NumPorts-1:0] hi_req, lo_req, hi_gnt, lo_gnt;
  logic [PortW-1:0]    hi_ptr, lo_ptr, hi_idx, lo_idx, gnt_idx, ptr_nxt;
  logic                hi_pend, lo_pend, sel_lo, any_gnt, lo_won;
  logic [7:0]          cnt, cnt_d;
  rd_req_t             pl_d, pl_q;

  assign hi_req = rd_req_i & rd_prio_i;
  assign lo_req = rd_req_i & ~rd_prio_i;

  wt_rr_arb_class #(.NumPorts(NumPorts), .PtrW(PortW)) i_hi (
    .ptr(hi_ptr), .req(hi_req), .gnt(hi_gnt), .idx(hi_idx), .any(hi_pend)
  );
  wt_rr_arb_class #(.NumPorts(NumPorts), .PtrW(PortW)) i_lo (
    .ptr(lo_ptr), .req(lo_req), .gnt(lo_gnt), .idx(lo_idx), .any(lo_pend)
  );

  // Low class wins when starved, or by default when no high request exists.
  assign sel_lo   = (starved_o & lo_pend) | ~hi_pend;
  assign rd_ack_o = (rst_i || wr_cl_vld_i) ? '0 : (sel_lo ? lo_gnt : hi_gnt);
  assign any_gnt  = |rd_ack_o;
  assign lo_won   = any_gnt & sel_lo;
  assign gnt_idx  = sel_lo ? lo_idx : hi_idx;
  assign ptr_nxt  = (gnt_idx == PortW'(NumPorts-1)) ? '0 : gnt_idx + PortW'(1);

  always_comb begin
    pl_d = pl_q;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (rd_ack_o[i]) begin
        pl_d.tag      = rd_tag_i[i*TagWidth +: TagWidth];
        pl_d.idx      = rd_idx_i[i*IdxWidth +: IdxWidth];
        pl_d.off      = rd_off_i[i*OffWidth +: OffWidth];
        pl_d.tag_only = rd_tag_only_i[i];
      end
    end
  end

  // Counting continues through write-blocked cycles so a busy refill cannot hide starvation.
  always_comb begin
    cnt_d = cnt;
    if (!lo_pend || lo_won) cnt_d = '0;
    else if (cnt != Limit)  cnt_d = cnt + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_ptr     <= '0;
      lo_ptr     <= '0;
      cnt        <= '0;
      starved_o  <= 1'b0;
      mem_vld_o  <= 1'b0;
      mem_port_o <= '0;
      pl_q       <= '0;
    end else begin
      cnt       <= cnt_d;
      starved_o <= (cnt_d == Limit);
      mem_vld_o <= any_gnt;
      pl_q      <= pl_d;
      if (any_gnt) begin
        mem_port_o <= gnt_idx;
        if (sel_lo) lo_ptr <= ptr_nxt;
        else        hi_ptr <= ptr_nxt;
      end
    end
  end

  assign mem_tag_o      = pl_q.tag;
  assign mem_idx_o      = pl_q.idx;
  assign mem_off_o      = pl_q.off;
  assign mem_tag_only_o = pl_q.tag_only;
endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed-vector scoreboard bench for the 4-port arbiter with a short starvation limit.
module tb_wt_dcache_rd_arb;
  localparam int NP = 4;
  localparam int TW = 16;
  localparam int IW = 8;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] req = '0, prio = '0, tonly;
  logic          wr = 1'b0;
  logic [NP*TW-1:0] tag;
  logic [NP*IW-1:0] idx;
  logic [NP*OW-1:0] off;
  logic [NP-1:0] ack;
  logic          mvld, mtonly, starved;
  logic [1:0]    mport;
  logic [TW-1:0] mtag;
  logic [IW-1:0] midx;
  logic [OW-1:0] moff;

  typedef struct {
    int         id;
    logic [3:0] ack;
    logic       vld;
    logic [1:0] port;
    logic       st;
    logic       chk;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int vec_id = 0;

  wt_dcache_rd_arb #(.NumPorts(NP), .TagWidth(TW), .IdxWidth(IW), .OffWidth(OW),
                     .StarveLimit(3)) dut (
    .clk_i(clk), .rst_i(rst), .rd_req_i(req), .rd_prio_i(prio), .rd_tag_only_i(tonly),
    .rd_tag_i(tag), .rd_idx_i(idx), .rd_off_i(off), .rd_ack_o(ack), .wr_cl_vld_i(wr),
    .mem_vld_o(mvld), .mem_port_o(mport), .mem_tag_o(mtag), .mem_idx_o(midx),
    .mem_off_o(moff), .mem_tag_only_o(mtonly), .starved_o(starved)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] tag_of(int p);
    return (p == 1) ? TW'('h2A) : TW'('h100 + p);
  endfunction
  function automatic logic [IW-1:0] idx_of(int p);
    return (p == 1) ? IW'('h13) : IW'('h40 + p);
  endfunction
  function automatic logic [OW-1:0] off_of(int p);
    return (p == 1) ? OW'(8) : OW'(p);
  endfunction

  initial begin
    for (int p = 0; p < NP; p++) begin
      tag[p*TW +: TW] = tag_of(p);
      idx[p*IW +: IW] = idx_of(p);
      off[p*OW +: OW] = off_of(p);
      tonly[p]        = (p == 1);
    end
  end

  task automatic cmp(input string name, input int id, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the hand-computed response for that cycle.
  task automatic step(input logic r, input logic w, input logic [3:0] rq, input logic [3:0] pr,
                      input logic [3:0] eack, input logic evld, input logic [1:0] eport,
                      input logic est, input logic echk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wr = w; req = rq; prio = pr;
    e.id = vec_id; e.ack = eack; e.vld = evld; e.port = eport; e.st = est; e.chk = echk;
    sb.push_back(e);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("rd_ack", e.id, 64'(ack), 64'(e.ack));
        cmp("mem_vld", e.id, 64'(mvld), 64'(e.vld));
        cmp("mem_port", e.id, 64'(mport), 64'(e.port));
        cmp("starved", e.id, 64'(starved), 64'(e.st));
        if (e.chk) begin
          cmp("mem_tag", e.id, 64'(mtag), 64'(tag_of(int'(e.port))));
          cmp("mem_idx", e.id, 64'(midx), 64'(idx_of(int'(e.port))));
          cmp("mem_off", e.id, 64'(moff), 64'(off_of(int'(e.port))));
          cmp("mem_tag_only", e.id, 64'(mtonly), 64'(e.port == 2'd1));
        end
      end
    end
  end

  initial begin : stim
    //      rst wr  req      prio     ack      vld port   st
    step(1, 0, 4'hF, 4'hF, 4'b0000, 0, 2'd0, 0, 0);   // reset state
    // round robin, all high
    step(0, 0, 4'hF, 4'hF, 4'b0001, 0, 2'd0, 0, 0);
    step(0, 0, 4'hF, 4'hF, 4'b0010, 1, 2'd0, 0, 0);
    step(0, 0, 4'hF, 4'hF, 4'b0100, 1, 2'd1, 0, 0);
    step(0, 0, 4'hF, 4'hF, 4'b1000, 1, 2'd2, 0, 0);
    step(0, 0, 4'hF, 4'hF, 4'b0001, 1, 2'd3, 0, 0);
    step(0, 0, 4'hF, 4'hF, 4'b0010, 1, 2'd0, 0, 0);
    step(0, 0, 4'hF, 4'hF, 4'b0100, 1, 2'd1, 0, 0);
    step(0, 0, 4'hF, 4'hF, 4'b1000, 1, 2'd2, 0, 0);
    step(0, 0, 4'h0, 4'h0, 4'b0000, 1, 2'd3, 0, 0);
    // payload capture on port 1 (low class), then hold while idle
    step(0, 0, 4'b0010, 4'h0, 4'b0010, 0, 2'd3, 0, 0);
    step(0, 0, 4'h0, 4'h0, 4'b0000, 1, 2'd1, 0, 1);
    step(0, 0, 4'h0, 4'h0, 4'b0000, 0, 2'd1, 0, 1);
    step(0, 0, 4'h0, 4'h0, 4'b0000, 0, 2'd1, 0, 1);
    // port 0 high vs port 2 low; limit 3 forces port 2 in the fourth cycle
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 0, 2'd1, 0, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 1, 2'd0, 0, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 1, 2'd0, 0, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0100, 1, 2'd0, 1, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 1, 2'd2, 0, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 1, 2'd0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 4'b0000, 1, 2'd0, 0, 0);
    // write block: counter keeps running, starved after 3 blocked cycles
    step(0, 1, 4'b0110, 4'b0010, 4'b0000, 0, 2'd0, 0, 0);
    step(0, 1, 4'b0110, 4'b0010, 4'b0000, 0, 2'd0, 0, 0);
    step(0, 1, 4'b0110, 4'b0010, 4'b0000, 0, 2'd0, 0, 0);
    step(0, 1, 4'b0110, 4'b0010, 4'b0000, 0, 2'd0, 1, 0);
    step(0, 0, 4'b0110, 4'b0010, 4'b0100, 0, 2'd0, 1, 0);
    step(0, 0, 4'h0, 4'h0, 4'b0000, 1, 2'd2, 0, 1);
    // reset mid-stream with ports 0/1 requesting
    step(0, 0, 4'b0011, 4'b0011, 4'b0010, 0, 2'd2, 0, 0);
    step(0, 0, 4'b0011, 4'b0011, 4'b0001, 1, 2'd1, 0, 0);
    step(1, 0, 4'b0011, 4'b0011, 4'b0000, 0, 2'd0, 0, 0);
    step(0, 0, 4'b0011, 4'b0011, 4'b0001, 0, 2'd0, 0, 0);
    step(0, 0, 4'b0011, 4'b0011, 4'b0010, 1, 2'd0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 4'b0000, 1, 2'd1, 0, 1);
    repeat (2) @(posedge clk);
    cmp("scoreboard_drained", -1, 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
